// File: rtl/mem_arbiter.sv
// Two-master (icache/dcache) arbiter in front of a single main-memory port.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise dcache has fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int BEATS      = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_req_valid,
    output logic                  ic_req_ready,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_resp_valid,

    input  logic                  dc_req_valid,
    output logic                  dc_req_ready,
    input  logic                  dc_req_rw,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [DATA_WIDTH-1:0] dc_req_data,
    output logic                  dc_resp_valid,

    output logic [DATA_WIDTH-1:0] resp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    localparam int CNT_W = ($clog2(BEATS + 1) > 1) ? $clog2(BEATS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           winner;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] beat_next;

    logic                  sel_rw;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

`ifdef MEM_ARB_RR_EN
    owner_e last_grant_q, last_grant_d;
`endif

    assign beat_next = beat_cnt_q + CNT_W'(1);

    always_comb begin
        winner = OWN_IC;
        if (ic_req_valid && dc_req_valid) begin
`ifdef MEM_ARB_RR_EN
            winner = (last_grant_q == OWN_DC) ? OWN_IC : OWN_DC;
`else
            winner = OWN_DC;
`endif
        end else if (dc_req_valid) begin
            winner = OWN_DC;
        end
    end

    // The icache only ever reads, so its write data is tied to zero.
    always_comb begin
        sel_rw   = 1'b0;
        sel_addr = ic_req_addr;
        sel_data = '0;
        if (owner_q == OWN_DC) begin
            sel_rw   = dc_req_rw;
            sel_addr = dc_req_addr;
            sel_data = dc_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IC;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= OWN_IC;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (ic_req_valid || dc_req_valid)) begin
            last_grant_d = winner;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    owner_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    if (sel_rw) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = WAIT_RESP;
                        beat_cnt_d = '0;
                    end
                end
            end
            WAIT_RESP: begin
                // Counter saturates at BEATS and is cleared by the next read handshake.
                if (mem_resp_valid) begin
                    beat_cnt_d = beat_next;
                    if (beat_next == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        ic_resp_valid = 1'b0;
        dc_resp_valid = 1'b0;
        case (state_q)
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = sel_rw;
                mem_req_addr  = sel_addr;
                mem_req_data  = sel_data;
                ic_req_ready  = (owner_q == OWN_IC) && mem_req_ready;
                dc_req_ready  = (owner_q == OWN_DC) && mem_req_ready;
            end
            WAIT_RESP: begin
                ic_resp_valid = (owner_q == OWN_IC) && mem_resp_valid;
                dc_resp_valid = (owner_q == OWN_DC) && mem_resp_valid;
            end
            default: begin
            end
        endcase
    end

    assign resp_data = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk;
    logic          reset;
    logic          ic_req_valid;
    logic          ic_req_ready;
    logic [AW-1:0] ic_req_addr;
    logic          ic_resp_valid;
    logic          dc_req_valid;
    logic          dc_req_ready;
    logic          dc_req_rw;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data;
    logic          dc_resp_valid;
    logic [DW-1:0] resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ic_req_valid   (ic_req_valid),
        .ic_req_ready   (ic_req_ready),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_rw      (dc_req_rw),
        .dc_req_addr    (dc_req_addr),
        .dc_req_data    (dc_req_data),
        .dc_resp_valid  (dc_resp_valid),
        .resp_data      (resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic icv, input logic [AW-1:0] ica,
                                 input logic dcv, input logic dcrw, input logic [AW-1:0] dca,
                                 input logic [DW-1:0] dcd, input logic mrdy);
        ic_req_valid  = icv;
        ic_req_addr   = ica;
        dc_req_valid  = dcv;
        dc_req_rw     = dcrw;
        dc_req_addr   = dca;
        dc_req_data   = dcd;
        mem_req_ready = mrdy;
    endtask

    // Drive n response beats; expIc/expDc are the per-beat resp_valid values expected.
    task automatic runBeats(input int n, input logic expIc, input logic expDc);
        logic [DW-1:0] pat;
        for (int i = 0; i < n; i++) begin
            pat = {4{32'hC0DE_0000 + 32'(i)}};
            mem_resp_valid = 1'b1;
            mem_resp_data  = pat;
            #1;
            checkBit("beat_ic_resp_valid", ic_resp_valid, expIc);
            checkBit("beat_dc_resp_valid", dc_resp_valid, expDc);
            checkOutput("beat_resp_data", resp_data, pat);
            tick();
        end
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        logic expDcWin [3];
`ifdef MEM_ARB_RR_EN
        expDcWin = '{1'b1, 1'b0, 1'b1};
`else
        expDcWin = '{1'b1, 1'b1, 1'b1};
`endif
        reset          = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        mem_resp_data = {4{32'h1234_5678}};
        #1;
        checkBit("rst_mem_req_valid", mem_req_valid, 1'b0);
        checkBit("rst_ic_req_ready", ic_req_ready, 1'b0);
        checkBit("rst_dc_req_ready", dc_req_ready, 1'b0);
        checkBit("rst_ic_resp_valid", ic_resp_valid, 1'b0);
        checkBit("rst_dc_resp_valid", dc_resp_valid, 1'b0);
        checkBit("rst_mem_req_rw", mem_req_rw, 1'b0);
        checkOutput("rst_mem_req_addr", DW'(mem_req_addr), 128'h0);
        checkOutput("rst_mem_req_data", mem_req_data, 128'h0);
        checkOutput("rst_resp_data", resp_data, {4{32'h1234_5678}});

        $display("[TB] icache read 0x40");
        tick();
        applyStimulus(1'b1, 28'h40, 1'b0, 1'b0, '0, '0, 1'b1);
        #1;
        checkBit("ic_rd_idle_mem_valid", mem_req_valid, 1'b0);
        tick();
        checkBit("ic_rd_mem_valid", mem_req_valid, 1'b1);
        checkOutput("ic_rd_addr", DW'(mem_req_addr), 128'h40);
        checkBit("ic_rd_rw", mem_req_rw, 1'b0);
        checkOutput("ic_rd_data", mem_req_data, 128'h0);
        checkBit("ic_rd_ic_ready", ic_req_ready, 1'b1);
        checkBit("ic_rd_dc_ready", dc_req_ready, 1'b0);
        tick();
        ic_req_valid = 1'b0;
        #1;
        checkBit("ic_rd_wait_mem_valid", mem_req_valid, 1'b0);
        checkBit("ic_rd_wait_ic_ready", ic_req_ready, 1'b0);
        runBeats(4, 1'b1, 1'b0);

        $display("[TB] spurious response in idle");
        mem_resp_valid = 1'b1;
        mem_resp_data  = {4{32'hDEAD_BEEF}};
        #1;
        checkBit("spur_ic_resp_valid", ic_resp_valid, 1'b0);
        checkBit("spur_dc_resp_valid", dc_resp_valid, 1'b0);
        checkBit("spur_mem_req_valid", mem_req_valid, 1'b0);
        checkOutput("spur_resp_data", resp_data, {4{32'hDEAD_BEEF}});
        tick();
        mem_resp_valid = 1'b0;

        $display("[TB] contention, dcache first then icache");
        applyStimulus(1'b1, 28'h200, 1'b1, 1'b0, 28'h300, '0, 1'b1);
        tick();
        checkOutput("cont_first_addr", DW'(mem_req_addr), 128'h300);
        checkBit("cont_first_dc_ready", dc_req_ready, 1'b1);
        checkBit("cont_first_ic_ready", ic_req_ready, 1'b0);
        tick();
        dc_req_valid = 1'b0;
        #1;
        checkBit("cont_wait_mem_valid", mem_req_valid, 1'b0);
        runBeats(4, 1'b0, 1'b1);
        checkBit("cont_idle_mem_valid", mem_req_valid, 1'b0);
        tick();
        checkOutput("cont_second_addr", DW'(mem_req_addr), 128'h200);
        checkBit("cont_second_ic_ready", ic_req_ready, 1'b1);
        checkBit("cont_second_dc_ready", dc_req_ready, 1'b0);
        tick();
        ic_req_valid = 1'b0;
        runBeats(4, 1'b1, 1'b0);

        $display("[TB] three back-to-back contended rounds");
        applyStimulus(1'b1, 28'h200, 1'b1, 1'b0, 28'h300, '0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            tick();
            checkOutput("rr_round_addr", DW'(mem_req_addr), expDcWin[r] ? 128'h300 : 128'h200);
            checkBit("rr_round_dc_ready", dc_req_ready, expDcWin[r]);
            checkBit("rr_round_ic_ready", ic_req_ready, !expDcWin[r]);
            tick();
            runBeats(4, !expDcWin[r], expDcWin[r]);
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;

        $display("[TB] dcache write with stalled memory");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 28'h100, {16{8'hA5}}, 1'b0);
        tick();
        for (int s = 0; s < 3; s++) begin
            checkBit("wr_stall_mem_valid", mem_req_valid, 1'b1);
            checkOutput("wr_stall_addr", DW'(mem_req_addr), 128'h100);
            checkOutput("wr_stall_data", mem_req_data, {16{8'hA5}});
            checkBit("wr_stall_rw", mem_req_rw, 1'b1);
            checkBit("wr_stall_dc_ready", dc_req_ready, 1'b0);
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        checkBit("wr_hs_dc_ready", dc_req_ready, 1'b1);
        tick();
        dc_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        checkBit("wr_post_dc_ready", dc_req_ready, 1'b0);
        checkBit("wr_post_mem_valid", mem_req_valid, 1'b0);
        checkBit("wr_post_dc_resp_valid", dc_resp_valid, 1'b0);
        mem_resp_valid = 1'b0;

        $display("[TB] reset in the middle of a read");
        applyStimulus(1'b1, 28'h80, 1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("mid_rst_addr", DW'(mem_req_addr), 128'h80);
        tick();
        ic_req_valid = 1'b0;
        runBeats(2, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkBit("mid_rst_mem_valid", mem_req_valid, 1'b0);
        checkBit("mid_rst_ic_ready", ic_req_ready, 1'b0);
        runBeats(2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
